// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch driver slice.
// Holds the FSM state encoding and the default timing constants used by the
// top level and the per-button debouncer.
package sr_pkg;

  // Command sequencer states; the encoding is fixed so that state values seen
  // in waveforms and in the latch block documentation stay in step.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GAP   = 2'd3
  } sr_state_t;

  // Default timing: debounce length, pulse width, quiet gap, counter width.
  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_PULSE_LEN  = 3;
  localparam int DEF_GAP_LEN    = 2;
  localparam int DEF_CNT_W      = 8;

  // Terminal count for a counter that starts at zero and runs for len cycles.
  function automatic int last_count(input int len);
    return len - 1;
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Button / latch-drive bundle of the SR latch driver.
// The master side owns the raw buttons and the latch q readback; the slave
// side (the driver itself) owns the latch drive and status outputs.
interface sr_latch_driver_if;

  logic set_btn;
  logic clr_btn;
  logic q_fb;
  logic s;
  logic r;
  logic busy;
  logic state_exp;
  logic conflict;
  logic err;

  modport master (
    output set_btn, clr_btn, q_fb,
    input  s, r, busy, state_exp, conflict, err
  );

  modport slave (
    input  set_btn, clr_btn, q_fb,
    output s, r, busy, state_exp, conflict, err
  );

endinterface

// File: rtl/sr_debounce.sv
// Per-button conditioning: 2-flop synchronizer, counting debouncer and a
// rising-edge strobe on the debounced level.
// The debounced level only changes after DEB_CYCLES consecutive synchronized
// samples that disagree with it; any agreeing sample restarts the count.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic dout,
  output logic rise
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(last_count(DEB_CYCLES));

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Two-stage synchronizer bringing the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din_raw;
      sync2 <= sync1;
    end
  end

  // Debounce counter and level; rise pulses in the same cycle the level goes high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        cnt  <= '0;
        dout <= sync2;
        rise <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// SR latch driver: turns debounced set/clear button edges into fixed-width
// s or r pulses separated by a quiet gap, and tracks the latch value that
// those pulses should have produced.
// Optional feature macro: SR_READBACK_EN -- when defined, the latch q output
// is synchronized and compared against the expected value at the end of each
// command; a mismatch sets a sticky err flag.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_LEN  = DEF_PULSE_LEN,
  parameter int GAP_LEN    = DEF_GAP_LEN,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  sr_latch_driver_if.slave  bus
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(last_count(PULSE_LEN));
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(last_count(GAP_LEN));

  sr_state_t        state;
  sr_state_t        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  logic set_level;
  logic clr_level;
  logic set_req;
  logic clr_req;
  logic unused_levels;

  logic conflict_nx;
  logic exp_nx;

  logic s_q;
  logic r_q;
  logic busy_q;
  logic conflict_q;
  logic state_exp_q;

  sr_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_set_deb (
    .clk     (clk),
    .rst     (rst),
    .din_raw (bus.set_btn),
    .dout    (set_level),
    .rise    (set_req)
  );

  sr_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_clr_deb (
    .clk     (clk),
    .rst     (rst),
    .din_raw (bus.clr_btn),
    .dout    (clr_level),
    .rise    (clr_req)
  );

  // Only the edge strobes drive the sequencer; the levels are kept for debug.
  assign unused_levels = set_level ^ clr_level;

  // Next-state logic: accept a lone request in IDLE, time the pulse, then the gap.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    conflict_nx = 1'b0;
    exp_nx      = state_exp_q;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (set_req && clr_req) begin
          conflict_nx = 1'b1;
        end else if (set_req) begin
          state_nx = SET_P;
        end else if (clr_req) begin
          state_nx = CLR_P;
        end
      end
      SET_P: begin
        if (cnt == PULSE_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
          exp_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      CLR_P: begin
        if (cnt == PULSE_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
          exp_nx   = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State and pulse/gap counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Registered latch drive and status, decoded from the upcoming state so they
  // line up with the state they describe and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      busy_q      <= 1'b0;
      conflict_q  <= 1'b0;
      state_exp_q <= 1'b0;
    end else begin
      s_q         <= (state_nx == SET_P);
      r_q         <= (state_nx == CLR_P);
      busy_q      <= (state_nx != IDLE);
      conflict_q  <= conflict_nx;
      state_exp_q <= exp_nx;
    end
  end

  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.busy      = busy_q;
  assign bus.conflict  = conflict_q;
  assign bus.state_exp = state_exp_q;

`ifdef SR_READBACK_EN
  logic q_sync1;
  logic q_sync2;
  logic err_q;

  // Synchronize the latch q readback into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sync1 <= 1'b0;
      q_sync2 <= 1'b0;
    end else begin
      q_sync1 <= bus.q_fb;
      q_sync2 <= q_sync1;
    end
  end

  // Sticky mismatch flag, sampled once per command on its last quiet cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state == GAP) && (cnt == GAP_LAST) && (q_sync2 != state_exp_q)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_q_fb;

  assign unused_q_fb = bus.q_fb;
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver.
// Stimulus pushes the expected pulse/conflict events into a queue; a monitor
// pops and compares whenever the driver starts an s or r pulse or strobes
// conflict. Honors SR_READBACK_EN for the err expectations.
module tb_sr_latch_driver;

  localparam int DEB     = 4;
  localparam int PULSE_C = 3;
  localparam int GAP_C   = 2;
  localparam int LAT     = 2 + DEB + 1;

  localparam logic [1:0] EV_SET  = 2'd0;
  localparam logic [1:0] EV_CLR  = 2'd1;
  localparam logic [1:0] EV_CONF = 2'd2;

`ifdef SR_READBACK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] kind;
    int         cyc;
    logic       exp_after;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic latch_q = 1'b0;
  logic stuck = 1'b0;
  ev_t  exp_q[$];

  sr_latch_driver_if bus ();

  sr_latch_driver #(
    .DEB_CYCLES (DEB),
    .PULSE_LEN  (PULSE_C),
    .GAP_LEN    (GAP_C),
    .CNT_W      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.q_fb = stuck ? 1'b0 : latch_q;

  task automatic check_output(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0b expected %0b at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic set_v, input logic clr_v);
    bus.set_btn = set_v;
    bus.clr_btn = clr_v;
  endtask

  task automatic expect_event(input logic [1:0] kind, input int at_cyc, input logic after);
    ev_t e;
    e.kind      = kind;
    e.cyc       = at_cyc;
    e.exp_after = after;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Environment model of the real SR latch driven by s/r.
  initial forever begin
    @(negedge clk);
    if (bus.s) latch_q = 1'b1;
    else if (bus.r) latch_q = 1'b0;
  end

  // Monitor: invariants every cycle, scoreboard pop on each observed event.
  initial begin
    logic s_prev, r_prev, busy_prev, after;
    int   width, busy_width;
    ev_t  e;
    s_prev = 0; r_prev = 0; busy_prev = 0; after = 0; width = 0; busy_width = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_prev = 0; r_prev = 0; busy_prev = 0; width = 0; busy_width = 0;
      end else begin
        check_output("s_and_r_exclusive", bus.s & bus.r, 1'b0);
        check_output("s_r_not_adjacent", (bus.s & r_prev) | (bus.r & s_prev), 1'b0);
        if ((bus.s && !s_prev) || (bus.r && !r_prev) || bus.conflict) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_event: s=%0b r=%0b conflict=%0b at cycle %0d, none required",
                     bus.s, bus.r, bus.conflict, cyc);
          end else begin
            e = exp_q.pop_front();
            check_int("event_kind", bus.conflict ? int'(EV_CONF) : (bus.s ? int'(EV_SET) : int'(EV_CLR)),
                      int'(e.kind));
            check_int("event_cycle", cyc, e.cyc);
            after = e.exp_after;
            if (bus.conflict) check_output("conflict_state_exp", bus.state_exp, e.exp_after);
            else check_output("busy_at_pulse_start", bus.busy, 1'b1);
          end
        end
        if (bus.s || bus.r) begin
          width++;
        end else if (s_prev || r_prev) begin
          check_int("pulse_width", width, PULSE_C);
          check_output("state_exp_first_gap", bus.state_exp, after);
          width = 0;
        end
        if (bus.busy) begin
          busy_width++;
        end else if (busy_prev) begin
          check_int("busy_width", busy_width, PULSE_C + GAP_C);
          busy_width = 0;
        end
        s_prev = bus.s; r_prev = bus.r; busy_prev = bus.busy;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int p;
    apply_stimulus(1'b0, 1'b0);
    #1 rst = 1'b1;

    // Reset state, held for 3 cycles.
    wait_cycles(3);
    check_output("rst_s", bus.s, 1'b0);
    check_output("rst_r", bus.r, 1'b0);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_state_exp", bus.state_exp, 1'b0);
    check_output("rst_conflict", bus.conflict, 1'b0);
    check_output("rst_err", bus.err, 1'b0);
    #2 rst = 1'b0;
    wait_cycles(10);
    check_output("idle_s", bus.s, 1'b0);
    check_output("idle_r", bus.r, 1'b0);
    check_output("idle_busy", bus.busy, 1'b0);

    // Clean set press.
    p = cyc;
    apply_stimulus(1'b1, 1'b0);
    expect_event(EV_SET, p + LAT, 1'b1);
    wait_cycles(LAT + 2);
    check_output("set_last_pulse_s", bus.s, 1'b1);
    check_output("set_before_gap_state_exp", bus.state_exp, 1'b0);
    wait_cycles(1);
    check_output("set_gap_state_exp", bus.state_exp, 1'b1);
    check_output("set_gap_busy", bus.busy, 1'b1);
    wait_cycles(2);
    check_output("set_after_gap_busy", bus.busy, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    // Bouncing set press: 10 toggles, then stable high.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus((i % 2) == 0, 1'b0);
      wait_cycles(1);
    end
    p = cyc;
    apply_stimulus(1'b1, 1'b0);
    expect_event(EV_SET, p + LAT, 1'b1);
    wait_cycles(20);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    // Both buttons on the same edge: conflict, no pulse, state_exp kept.
    p = cyc;
    apply_stimulus(1'b1, 1'b1);
    expect_event(EV_CONF, p + LAT, 1'b1);
    wait_cycles(15);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    // Clear edge landing inside a set pulse is dropped.
    p = cyc;
    apply_stimulus(1'b1, 1'b0);
    expect_event(EV_SET, p + LAT, 1'b1);
    wait_cycles(2);
    apply_stimulus(1'b1, 1'b1);
    wait_cycles(20);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    // Reset asserted in the second cycle of an r pulse.
    p = cyc;
    apply_stimulus(1'b0, 1'b1);
    expect_event(EV_CLR, p + LAT, 1'b0);
    wait_cycles(LAT + 1);
    check_output("mid_r_before_rst", bus.r, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_output("mid_rst_r", bus.r, 1'b0);
    check_output("mid_rst_s", bus.s, 1'b0);
    check_output("mid_rst_state_exp", bus.state_exp, 1'b0);
    check_output("mid_rst_busy", bus.busy, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(3);
    #2 rst = 1'b0;
    wait_cycles(15);
    check_output("restart_idle_busy", bus.busy, 1'b0);
    p = cyc;
    apply_stimulus(1'b1, 1'b0);
    expect_event(EV_SET, p + LAT, 1'b1);
    wait_cycles(20);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    // Readback with q stuck low after a set command.
    check_output("rb_err_before", bus.err, 1'b0);
    stuck = 1'b1;
    p = cyc;
    apply_stimulus(1'b1, 1'b0);
    expect_event(EV_SET, p + LAT, 1'b1);
    wait_cycles(LAT + PULSE_C + GAP_C - 1);
    check_output("rb_err_last_gap", bus.err, 1'b0);
    wait_cycles(1);
    check_output("rb_err_after_gap", bus.err, ERR_EXP);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(10);
    check_output("rb_err_sticky", bus.err, ERR_EXP);
    #2 rst = 1'b1;
    #1;
    check_output("rb_err_cleared", bus.err, 1'b0);
    wait_cycles(2);
    #2 rst = 1'b0;
    stuck = 1'b0;
    wait_cycles(5);

    check_int("events_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
